// File: rtl/tage_pkg.sv
// Shared predictor definitions: sequencer phase encoding and the number of
// active phases one branch occupies.
package tage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INDEX    = 3'd1,
    ST_READ     = 3'd2,
    ST_RESOLVE  = 3'd3,
    ST_UPD_PRED = 3'd4,
    ST_UPD      = 3'd5
  } state_t;

  localparam int PHASE_COUNT = 5;

endpackage

// File: rtl/branch_record_fifo.sv
// Power-of-two FIFO holding resolved branch records between the upstream
// core and the predictor sequencer. Head data is presented combinationally.
module branch_record_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_trace_sequencer.sv
// Drains buffered branch records into the predictor, stepping each branch
// through index, read, resolve, predictor-update and table-update phases.
module branch_trace_sequencer
  import tage_pkg::*;
#(
  parameter int ADDRESS_SIZE           = 32,
  parameter int FIFO_DEPTH             = 4,
  parameter int INSTRUCTION_INDEX_SIZE = 32
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDRESS_SIZE-1:0]           in_pc,
  input  logic                              in_taken,
  input  logic                              pause,
  output logic [ADDRESS_SIZE-1:0]           pc,
  output logic                              Actual_branch,
  output logic                              index_tag_enable,
  output logic                              table_read_en,
  output logic                              update_predictor_enable,
  output logic                              update_enable,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] issued_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = ADDRESS_SIZE + 1;

  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            pop;
  logic            can_start;
  logic [RW-1:0]   head;

  assign in_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign can_start = (fifo_level != '0) && !pause;
  assign pop       = ((state == ST_IDLE) || (state == ST_UPD)) && can_start;
  assign busy      = (state != ST_IDLE);

  branch_record_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .reset     (reset),
    .push      (push),
    .push_data ({in_pc, in_taken}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= '0;
      Actual_branch <= 1'b0;
      issued_count  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) {pc, Actual_branch} <= head;
      if (state == ST_UPD) issued_count <= issued_count + 1'b1;
    end
  end

  // Moore strobes; RESOLVE deliberately drives nothing so the registered
  // comparators settle before the update phases.
  always_comb begin
    state_nxt               = state;
    index_tag_enable        = 1'b0;
    table_read_en           = 1'b0;
    update_predictor_enable = 1'b0;
    update_enable           = 1'b0;
    case (state)
      ST_IDLE:     state_nxt = can_start ? ST_INDEX : ST_IDLE;
      ST_INDEX: begin
        index_tag_enable = 1'b1;
        state_nxt        = ST_READ;
      end
      ST_READ: begin
        table_read_en = 1'b1;
        state_nxt     = ST_RESOLVE;
      end
      ST_RESOLVE:  state_nxt = ST_UPD_PRED;
      ST_UPD_PRED: begin
        update_predictor_enable = 1'b1;
        state_nxt               = ST_UPD;
      end
      ST_UPD: begin
        update_enable = 1'b1;
        state_nxt     = can_start ? ST_INDEX : ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Directed bench for branch_trace_sequencer: reset, single branch, full FIFO,
// back-to-back drain, pause handling, mid-branch reset and counter wrap.
module tb_branch_trace_sequencer;

  localparam int AS = 32;
  localparam int FD = 4;
  localparam int IS = 4;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_IDX  = 4'b1000;
  localparam logic [3:0] S_RD   = 4'b0100;
  localparam logic [3:0] S_UPP  = 4'b0010;
  localparam logic [3:0] S_UPD  = 4'b0001;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AS-1:0] in_pc;
  logic          in_taken;
  logic          pause;
  logic [AS-1:0] pc;
  logic          Actual_branch;
  logic          index_tag_enable;
  logic          table_read_en;
  logic          update_predictor_enable;
  logic          update_enable;
  logic          busy;
  logic [2:0]    fifo_level;
  logic [IS-1:0] issued_count;
  logic [3:0]    strb;

  int checks   = 0;
  int failures = 0;

  assign strb = {index_tag_enable, table_read_en, update_predictor_enable, update_enable};

  always #5 CLK = ~CLK;

  branch_trace_sequencer #(
    .ADDRESS_SIZE           (AS),
    .FIFO_DEPTH             (FD),
    .INSTRUCTION_INDEX_SIZE (IS)
  ) dut (
    .CLK                     (CLK),
    .reset                   (reset),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_pc                   (in_pc),
    .in_taken                (in_taken),
    .pause                   (pause),
    .pc                      (pc),
    .Actual_branch           (Actual_branch),
    .index_tag_enable        (index_tag_enable),
    .table_read_en           (table_read_en),
    .update_predictor_enable (update_predictor_enable),
    .update_enable           (update_enable),
    .busy                    (busy),
    .fifo_level              (fifo_level),
    .issued_count            (issued_count)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [AS-1:0] exp_pc    [5];
  logic          exp_tk    [5];
  logic [2:0]    exp_level [5];

  initial begin
    exp_pc    = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h600};
    exp_tk    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_level = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd0};

    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_taken = 1'b0; pause = 1'b0;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_issued", 64'(issued_count), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_strb", 64'(strb), 64'(S_NONE));
    reset = 1'b0;

    // Single branch: push on first edge, INDEX on the second.
    in_valid = 1'b1; in_pc = 32'h0000_1234; in_taken = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_level", 64'(fifo_level), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);
    step();
    chk("single_idx", 64'(strb), 64'(S_IDX));
    chk("single_pc", 64'(pc), 64'h1234);
    chk("single_tk", 64'(Actual_branch), 64'd1);
    chk("single_pop", 64'(fifo_level), 64'd0);
    step(); chk("single_rd", 64'(strb), 64'(S_RD));
    step(); chk("single_res", 64'(strb), 64'(S_NONE));
    chk("single_res_busy", 64'(busy), 64'd1);
    step(); chk("single_upp", 64'(strb), 64'(S_UPP));
    step(); chk("single_upd", 64'(strb), 64'(S_UPD));
    chk("single_upd_pc", 64'(pc), 64'h1234);
    chk("single_upd_cnt", 64'(issued_count), 64'd0);
    step();
    chk("single_done_busy", 64'(busy), 64'd0);
    chk("single_done_cnt", 64'(issued_count), 64'd1);
    chk("single_hold_pc", 64'(pc), 64'h1234);

    // Fill the FIFO while paused; a fifth offer must be ignored.
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = exp_pc[i]; in_taken = exp_tk[i];
      step();
    end
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    in_pc = 32'h500; in_taken = 1'b0;
    step();
    in_valid = 1'b0;
    chk("full_ignored", 64'(fifo_level), 64'd4);
    chk("full_paused", 64'(busy), 64'd0);

    // Drain back-to-back; one push lands on an UPD edge alongside a pop.
    pause = 1'b0;
    step();
    for (int c = 0; c < 25; c++) begin
      chk("drain_busy", 64'(busy), 64'd1);
      if (c % 5 == 0) begin
        chk("drain_idx", 64'(strb), 64'(S_IDX));
        chk("drain_pc", 64'(pc), 64'(exp_pc[c/5]));
        chk("drain_tk", 64'(Actual_branch), 64'(exp_tk[c/5]));
        chk("drain_level", 64'(fifo_level), 64'(exp_level[c/5]));
      end
      if (c == 9) begin
        in_valid = 1'b1; in_pc = 32'h600; in_taken = 1'b1;
      end
      step();
      in_valid = 1'b0;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    chk("drain_cnt", 64'(issued_count), 64'd6);

    // Pause raised during READ lets the current branch finish, then holds.
    pause = 1'b1;
    in_valid = 1'b1; in_pc = 32'h700; in_taken = 1'b0;
    step();
    in_pc = 32'h800; in_taken = 1'b1;
    step();
    in_valid = 1'b0;
    pause = 1'b0;
    step(); chk("pause_idx", 64'(strb), 64'(S_IDX));
    chk("pause_pc", 64'(pc), 64'h700);
    step(); chk("pause_rd", 64'(strb), 64'(S_RD));
    pause = 1'b1;
    step(); chk("pause_res", 64'(strb), 64'(S_NONE));
    step(); chk("pause_upp", 64'(strb), 64'(S_UPP));
    step(); chk("pause_upd", 64'(strb), 64'(S_UPD));
    step();
    chk("pause_idle", 64'(busy), 64'd0);
    chk("pause_level", 64'(fifo_level), 64'd1);
    chk("pause_cnt", 64'(issued_count), 64'd7);
    step(); step();
    chk("pause_hold", 64'(busy), 64'd0);
    chk("pause_hold_pc", 64'(pc), 64'h700);
    pause = 1'b0;
    step(); chk("resume_idx", 64'(strb), 64'(S_IDX));
    chk("resume_pc", 64'(pc), 64'h800);
    step(); step(); step(); step();
    chk("resume_upd", 64'(strb), 64'(S_UPD));
    step();
    chk("resume_cnt", 64'(issued_count), 64'd8);

    // Reset asserted during UPD_PRED with another record queued.
    in_valid = 1'b1; in_pc = 32'h900; in_taken = 1'b1;
    step();
    in_pc = 32'hA00;
    step();
    in_valid = 1'b0;
    chk("abort_idx", 64'(strb), 64'(S_IDX));
    step(); step(); step();
    chk("abort_upp", 64'(strb), 64'(S_UPP));
    reset = 1'b1;
    #1;
    chk("abort_async_strb", 64'(strb), 64'(S_NONE));
    chk("abort_async_busy", 64'(busy), 64'd0);
    chk("abort_async_pc", 64'(pc), 64'd0);
    step();
    chk("abort_strb", 64'(strb), 64'(S_NONE));
    chk("abort_level", 64'(fifo_level), 64'd0);
    chk("abort_cnt", 64'(issued_count), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Sixteen completions wrap the 4-bit issued counter back to zero.
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_pc = 32'(k); in_taken = k[0];
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) step();
      chk("wrap_cnt", 64'(issued_count), 64'((k + 1) % 16));
    end
    chk("wrap_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
